pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall scheduler for the 5-stage pipelined CPU. It drives the write and flush controls of the IF/ID and ID/EX pipeline registers and the PC write enable. It resolves load-use hazards, taken-branch flushes and multi-cycle MDU (mul/div) occupancy through a small FSM with a down-counter. A saturating stall-cycle counter is also exposed for performance measurement.

## Interface
- MDU_LAT, 8, total stall cycles for one MDU op; legal range 2..15
- CNT_W, 4, width of the MDU down-counter; must satisfy 2^CNT_W > MDU_LAT-1

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- id_mdu_i  in  1  ID instruction is an MDU op
- ex_memread_i  in  1  EX instruction is a load
- ex_rt_i  in  5  destination rt of the EX instruction
- branch_taken_i  in  1  branch in EX resolved taken this cycle
- pc_write_o  out  1  PC write enable
- if_id_write_o  out  1  IF/ID write enable
- if_id_flush_o  out  1  IF/ID flush
- id_ex_flush_o  out  1  ID/EX flush (bubble insert)
- mdu_busy_o  out  1  FSM in MDU_BUSY
- state_o  out  1  0=RUN, 1=MDU_BUSY
- stall_cnt_o  out  16  stall cycles since reset, saturating at 0xFFFF

## Operation
- FSM states: RUN, MDU_BUSY. Down-counter cnt is CNT_W bits wide.
- Control outputs are combinational from the current state, cnt and inputs. State, cnt and stall_cnt_o are registered.
- Stall pattern: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, if_id_flush_o=0.
- Normal pattern: pc_write_o=1, if_id_write_o=1, both flushes 0.
- Load-use hazard (LU): ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Priority per cycle, highest first:
  1. branch_taken_i: pc_write_o=1, if_id_write_o=1, if_id_flush_o=1, id_ex_flush_o=1. Next state RUN, cnt<=0. This aborts any MDU stall.
  2. MDU_BUSY with cnt!=0: stall pattern; cnt<=cnt-1.
  3. MDU_BUSY with cnt==0: normal pattern (release cycle; the MDU op advances to EX). Next state RUN. id_mdu_i is not re-evaluated this cycle.
  4. RUN with LU: stall pattern; state unchanged.
  5. RUN with id_mdu_i: stall pattern; cnt<=MDU_LAT-1; next state MDU_BUSY.
  6. Otherwise: normal pattern.
- LU is ignored in MDU_BUSY: EX holds a bubble there.
- stall_cnt_o increments on every cycle with pc_write_o=0 and stops at 0xFFFF.

## Timing
- Reset (asynchronous, rst_i=1): state=RUN, cnt=0, stall_cnt_o=0, mdu_busy_o=0, state_o=0. With quiet inputs, control outputs show the normal pattern.
- Reset is honoured mid-stall: the FSM returns to RUN immediately, with no release cycle.
- LU stall: exactly 1 cycle. The following cycle sees the bubble in EX, so LU is false.
- MDU stall: exactly MDU_LAT cycles, counting the entry cycle in RUN plus MDU_LAT-1 cycles in MDU_BUSY. The release cycle follows them.
- Branch and stall in the same cycle: the branch wins, with zero added stall.
- LU and id_mdu_i in the same cycle: 1 LU stall, then MDU entry on the next cycle.
- Back-to-back MDU ops: the second op enters from RUN one cycle after the release cycle.

## Configuration
- PIPE_HAZARD_CTRL_MDU_EN defined: MDU_BUSY state, cnt and id_mdu_i handling are present as described above.
- Undefined: id_mdu_i is ignored, the FSM stays in RUN, mdu_busy_o=0 and state_o=0. Only branch flush, LU and stall_cnt_o logic remain.

## Test plan
- Reset asserted mid-MDU stall (cnt=3) -> state_o=0, cnt=0, stall_cnt_o=0 asynchronously. Normal pattern on the next edge with quiet inputs.
- ex_memread_i=1, ex_rt_i=5, id_rs_i=5 for 1 cycle -> one cycle of pc_write_o=0, id_ex_flush_o=1, stall_cnt_o=1. Repeat with ex_rt_i=0 -> no stall.
- id_mdu_i=1 held, MDU_LAT=4 -> 4 stall cycles, then 1 release cycle with the normal pattern and state_o back to 0. stall_cnt_o=4.
- branch_taken_i=1 on the 2nd MDU_BUSY cycle -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1 that cycle. RUN on the next cycle.
- LU and id_mdu_i asserted together -> 1 LU stall, then MDU_LAT stall cycles. Total stall_cnt_o=1+MDU_LAT.
- Macro undefined, id_mdu_i=1 -> normal pattern and mdu_busy_o=0 throughout.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/stall scheduler for the 5-stage pipeline
//
// Optional feature macro: PIPE_HAZARD_CTRL_MDU_EN (MDU occupancy FSM + down-counter)
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   id_rs_i, id_rt_i      source fields of the ID instruction
//   id_uses_rt_i          ID instruction reads rt
//   id_mdu_i              ID instruction is a mul/div op
//   ex_memread_i, ex_rt_i EX instruction is a load, and its destination
//   branch_taken_i        EX branch resolved taken
//   pc_write_o            PC write enable
//   if_id_write_o         IF/ID write enable
//   if_id_flush_o         IF/ID flush
//   id_ex_flush_o         ID/EX flush (bubble)
//   mdu_busy_o, state_o   FSM state (1 = MDU_BUSY)
//   stall_cnt_o           saturating count of cycles with pc_write_o=0
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        id_mdu_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        branch_taken_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mdu_busy_o,
  output logic        state_o,
  output logic [15:0] stall_cnt_o
);

  // The entry cycle in RUN is the first stall, so BUSY holds for MDU_LAT-1.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MDU_LAT - 1);

  logic        lu;
  logic        stall;
  logic [15:0] stall_cnt_q;

  assign lu = ex_memread_i && (ex_rt_i != 5'd0) &&
              ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

`ifdef PIPE_HAZARD_CTRL_MDU_EN
  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (branch_taken_i) begin
      // A taken branch squashes the MDU op still sitting in ID.
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MDU_BUSY: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
          else             state_q <= RUN;  // release cycle, id_mdu_i not re-sampled
        end
        default: begin
          // A load-use stall takes precedence; MDU entry retries next cycle.
          if (!lu && id_mdu_i) begin
            state_q <= MDU_BUSY;
            cnt_q   <= LAT_M1;
          end
        end
      endcase
    end
  end

  assign mdu_busy_o = (state_q == MDU_BUSY);
  assign state_o    = (state_q == MDU_BUSY);

  always_comb begin
    stall = 1'b0;
    if (!branch_taken_i) begin
      // In MDU_BUSY EX holds a bubble, so LU cannot be true there.
      if (state_q == MDU_BUSY) stall = (cnt_q != '0);
      else                     stall = lu | id_mdu_i;
    end
  end
`else
  logic unused_mdu;
  assign unused_mdu = id_mdu_i ^ (^LAT_M1);

  assign mdu_busy_o = 1'b0;
  assign state_o    = 1'b0;

  always_comb begin
    stall = 1'b0;
    if (!branch_taken_i) stall = lu;
  end
`endif

  assign pc_write_o    = ~stall;
  assign if_id_write_o = ~stall;
  assign if_id_flush_o = branch_taken_i;
  assign id_ex_flush_o = stall | branch_taken_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
`ifdef PIPE_HAZARD_CTRL_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
  logic        id_uses_rt_i, id_mdu_i, ex_memread_i, branch_taken_i;
  logic        pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o;
  logic        mdu_busy_o, state_o;
  logic [15:0] stall_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
    .id_mdu_i(id_mdu_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .mdu_busy_o(mdu_busy_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining MDU stall cycles after entry, plus a pending release flag.
  int mdu_left     = 0;
  bit release_pend = 0;
  int exp_cnt      = 0;

  always @(negedge clk_i) begin
    bit lu, busy, e_stall, e_br;
    if (rst_i) begin
      mdu_left = 0; release_pend = 0; exp_cnt = 0;
    end
    lu = ex_memread_i && (ex_rt_i != 0) &&
         ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    busy    = (mdu_left > 0) || release_pend;
    e_br    = branch_taken_i;
    e_stall = 1'b0;
    if (e_br)                            e_stall = 1'b0;
    else if (mdu_left > 0)               e_stall = 1'b1;
    else if (release_pend)               e_stall = 1'b0;
    else if (lu)                         e_stall = 1'b1;
    else if (MDU_ON && id_mdu_i)         e_stall = 1'b1;

    chk("m_pc_write",  32'(pc_write_o),    32'(!e_stall));
    chk("m_ifid_wr",   32'(if_id_write_o), 32'(!e_stall));
    chk("m_ifid_fl",   32'(if_id_flush_o), 32'(e_br));
    chk("m_idex_fl",   32'(id_ex_flush_o), 32'(e_stall || e_br));
    chk("m_mdu_busy",  32'(mdu_busy_o),    32'(busy));
    chk("m_state",     32'(state_o),       32'(busy));
    chk("m_stall_cnt", 32'(stall_cnt_o),   32'(exp_cnt));

    if (!rst_i) begin
      if (e_stall && exp_cnt < 65535) exp_cnt++;
      if (e_br) begin
        mdu_left = 0; release_pend = 0;
      end else if (mdu_left > 0) begin
        mdu_left--;
        if (mdu_left == 0) release_pend = 1;
      end else if (release_pend) begin
        release_pend = 0;
      end else if (!lu && MDU_ON && id_mdu_i) begin
        mdu_left = LAT - 1;
        if (mdu_left == 0) release_pend = 1;
      end
    end
  end

  task automatic quiet();
    id_rs_i = 0; id_rt_i = 0; ex_rt_i = 0;
    id_uses_rt_i = 0; id_mdu_i = 0; ex_memread_i = 0; branch_taken_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic reset_dut();
    quiet(); rst_i = 1; tick(); rst_i = 0;
  endtask

  initial begin
    rst_i = 1; quiet();
    tick(); tick(); #1;
    chk("rst_pc",    32'(pc_write_o),  32'd1);
    chk("rst_cnt",   32'(stall_cnt_o), 32'd0);
    chk("rst_state", 32'(state_o),     32'd0);
    chk("rst_busy",  32'(mdu_busy_o),  32'd0);
    rst_i = 0; tick();

    // Load-use on rs
    ex_memread_i = 1; ex_rt_i = 5; id_rs_i = 5; #1;
    chk("lu_pc",   32'(pc_write_o),    32'd0);
    chk("lu_idex", 32'(id_ex_flush_o), 32'd1);
    chk("lu_ifid", 32'(if_id_flush_o), 32'd0);
    tick(); quiet();
    chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
    // r0 destination never hazards
    ex_memread_i = 1; ex_rt_i = 0; id_rs_i = 0; #1;
    chk("lu_r0_pc", 32'(pc_write_o), 32'd1);
    tick(); quiet();
    chk("lu_r0_cnt", 32'(stall_cnt_o), 32'd1);
    // rt path only counts when id_uses_rt_i
    ex_memread_i = 1; ex_rt_i = 7; id_rt_i = 7; id_rs_i = 3; id_uses_rt_i = 1; #1;
    chk("lu_rt_pc", 32'(pc_write_o), 32'd0);
    tick(); id_uses_rt_i = 0; #1;
    chk("lu_rt_unused_pc", 32'(pc_write_o), 32'd1);
    tick(); quiet();
    chk("lu_rt_cnt", 32'(stall_cnt_o), 32'd2);
    // Branch beats load-use
    ex_memread_i = 1; ex_rt_i = 5; id_rs_i = 5; branch_taken_i = 1; #1;
    chk("br_pc",   32'(pc_write_o),    32'd1);
    chk("br_ifid", 32'(if_id_flush_o), 32'd1);
    chk("br_idex", 32'(id_ex_flush_o), 32'd1);
    tick(); quiet();
    chk("br_cnt", 32'(stall_cnt_o), 32'd2);

`ifdef PIPE_HAZARD_CTRL_MDU_EN
    // MDU op held: LAT stalls then one release cycle
    reset_dut(); id_mdu_i = 1;
    for (int i = 0; i < LAT; i++) begin
      #1 chk("mdu_stall_pc", 32'(pc_write_o), 32'd0);
      tick();
    end
    #1;
    chk("mdu_rel_pc",    32'(pc_write_o), 32'd1);
    chk("mdu_rel_state", 32'(state_o),    32'd1);
    tick(); quiet();
    chk("mdu_cnt",       32'(stall_cnt_o), 32'(LAT));
    chk("mdu_run_state", 32'(state_o),     32'd0);

    // Branch on the 2nd MDU_BUSY cycle
    reset_dut(); id_mdu_i = 1; tick(); id_mdu_i = 0; tick();
    branch_taken_i = 1; #1;
    chk("mbr_pc",   32'(pc_write_o),    32'd1);
    chk("mbr_ifid", 32'(if_id_flush_o), 32'd1);
    chk("mbr_idex", 32'(id_ex_flush_o), 32'd1);
    tick(); quiet(); #1;
    chk("mbr_state", 32'(state_o),     32'd0);
    chk("mbr_cnt",   32'(stall_cnt_o), 32'd2);

    // LU and MDU together
    reset_dut();
    ex_memread_i = 1; ex_rt_i = 5; id_rs_i = 5; id_mdu_i = 1;
    tick(); ex_memread_i = 0;
    repeat (LAT) tick();
    id_mdu_i = 0; tick();
    chk("lumdu_cnt", 32'(stall_cnt_o), 32'(1 + LAT));

    // Async reset mid-stall (cnt=3)
    reset_dut(); id_mdu_i = 1; tick(); id_mdu_i = 0; #1;
    chk("mrst_pre_state", 32'(state_o), 32'd1);
    rst_i = 1; #1;
    chk("mrst_state", 32'(state_o),     32'd0);
    chk("mrst_busy",  32'(mdu_busy_o),  32'd0);
    chk("mrst_cnt",   32'(stall_cnt_o), 32'd0);
    tick(); rst_i = 0; #1;
    chk("mrst_pc", 32'(pc_write_o), 32'd1);
    tick();
`else
    reset_dut(); id_mdu_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("nomdu_pc",   32'(pc_write_o), 32'd1);
      chk("nomdu_busy", 32'(mdu_busy_o), 32'd0);
      tick();
    end
    quiet();
    chk("nomdu_cnt", 32'(stall_cnt_o), 32'd0);
`endif

    // Randomized traffic; small register range makes hazards frequent
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      rst_i          = ($urandom_range(0, 79) == 0);
      ex_memread_i   = $urandom_range(0, 1);
      ex_rt_i        = 5'($urandom_range(0, 3));
      id_rs_i        = 5'($urandom_range(0, 3));
      id_rt_i        = 5'($urandom_range(0, 3));
      id_uses_rt_i   = $urandom_range(0, 1);
      id_mdu_i       = ($urandom_range(0, 5) == 0);
      branch_taken_i = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst_i = 0; quiet(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
